// File: rtl/xm_bus_pkg.sv
// Shared types and defaults for the external Wishbone-classic bus arbiter.
//   arb_state_t : arbiter FSM states (StFlush only exists with XM_ARB_TIMEOUT_EN)
//   DEF_*       : default bus geometry and stall timeout
//   cnt_width() : width of a counter that must hold the value TIMEOUT_CYC itself
// Optional feature macro: XM_ARB_TIMEOUT_EN.
package xm_bus_pkg;

  localparam int unsigned DEF_WORD        = 16;
  localparam int unsigned DEF_ADR_W       = 15;
  localparam int unsigned DEF_TIMEOUT_CYC = 64;
  localparam int unsigned DEF_CNT_W       = $clog2(DEF_TIMEOUT_CYC + 1);

`ifdef XM_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StOwned, StFlush} arb_state_t;
`else
  typedef enum logic [0:0] {StIdle, StOwned} arb_state_t;
`endif

  function automatic int unsigned cnt_width(input int unsigned cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/xm_rr_picker.sv
// Round-robin pick: returns the first requester strictly after the pointer, wrapping.
//   req_i      : request vector
//   ptr_i      : index of the most recently granted master
//   pick_o     : one-hot winner (0 if no requests)
//   pick_idx_o : binary index of the winner
//   valid_o    : at least one request present
module xm_rr_picker #(
  parameter int unsigned NUM_MASTERS = 2,
  localparam int unsigned IdxW = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IdxW-1:0]        ptr_i,
  output logic [NUM_MASTERS-1:0] pick_o,
  output logic [IdxW-1:0]        pick_idx_o,
  output logic                   valid_o
);

  always_comb begin
    pick_o     = '0;
    pick_idx_o = '0;
    valid_o    = 1'b0;
    // Offset 1 first so the last owner is considered last.
    for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
      logic [IdxW-1:0] idx;
      idx = IdxW'((32'(ptr_i) + off) % NUM_MASTERS);
      if (!valid_o && req_i[idx]) begin
        valid_o     = 1'b1;
        pick_o[idx] = 1'b1;
        pick_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/xm_bus_arbiter.sv
// Round-robin arbiter for the single external Wishbone-classic bus. The grant is held
// for the owner's whole cycle (cyc high); at least one idle cycle separates owners.
// Optional macro XM_ARB_TIMEOUT_EN adds a stalled-strobe timeout that pulses m_err_o to
// the owner, kills cyc/stb and waits in StFlush until the owner releases cyc.
//   clk_i, arst_i (async, active-low)
//   m_*_i   : flattened per-master cyc/stb/we/sel/adr/dat
//   m_ack_o, m_err_o : routed to the owner only; m_dat_o : slave read data broadcast
//   gnt_o   : one-hot owner, 0 when no owner
//   cyc_o, stb_o, we_o, sel_o, adr_o, dat_o : slave side; ack_i, dat_i from slave
module xm_bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned WORD        = xm_bus_pkg::DEF_WORD,
  parameter int unsigned ADR_W       = xm_bus_pkg::DEF_ADR_W,
  parameter int unsigned TIMEOUT_CYC = xm_bus_pkg::DEF_TIMEOUT_CYC
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic [NUM_MASTERS-1:0]       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [2*NUM_MASTERS-1:0]     m_sel_i,
  input  logic [ADR_W*NUM_MASTERS-1:0] m_adr_i,
  input  logic [WORD*NUM_MASTERS-1:0]  m_dat_i,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic [WORD-1:0]              m_dat_o,
  output logic [NUM_MASTERS-1:0]       gnt_o,
  output logic                         cyc_o,
  output logic                         stb_o,
  output logic                         we_o,
  output logic [1:0]                   sel_o,
  output logic [ADR_W-1:0]             adr_o,
  output logic [WORD-1:0]              dat_o,
  input  logic                         ack_i,
  input  logic [WORD-1:0]              dat_i
);
  import xm_bus_pkg::*;

  localparam int unsigned IdxW = $clog2(NUM_MASTERS);

  arb_state_t             state_q, state_d;
  logic [IdxW-1:0]        owner_q, owner_d, ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [NUM_MASTERS-1:0] pick;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_valid;

  logic             own_cyc, own_stb, own_we;
  logic [1:0]       own_sel;
  logic [ADR_W-1:0] own_adr;
  logic [WORD-1:0]  own_dat;
  logic             timeout;

  xm_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .req_i     (m_cyc_i),
    .ptr_i     (ptr_q),
    .pick_o    (pick),
    .pick_idx_o(pick_idx),
    .valid_o   (pick_valid)
  );

  // Owner's bus port, selected by the registered owner index.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (owner_q == IdxW'(k)) begin
        own_cyc = m_cyc_i[k];
        own_stb = m_stb_i[k];
        own_we  = m_we_i[k];
        own_sel = m_sel_i[2*k +: 2];
        own_adr = m_adr_i[ADR_W*k +: ADR_W];
        own_dat = m_dat_i[WORD*k +: WORD];
      end
    end
  end

`ifdef XM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = cnt_width(TIMEOUT_CYC);
  logic [CntW-1:0] cnt_q, cnt_d;

  // An ack in the expiry cycle wins over the error.
  assign timeout = (state_q == StOwned) && own_cyc && (cnt_q == CntW'(TIMEOUT_CYC)) && !ack_i;

  always_comb begin
    cnt_d = cnt_q;
    if (ack_i || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == StOwned) && own_cyc && own_stb) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StOwned;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          gnt_d   = pick;
        end
      end
      StOwned: begin
        if (!own_cyc) begin
          state_d = StIdle;
          gnt_d   = '0;
`ifdef XM_ARB_TIMEOUT_EN
        end else if (timeout) begin
          state_d = StFlush;
          gnt_d   = '0;
`endif
        end
      end
`ifdef XM_ARB_TIMEOUT_EN
      StFlush: begin
        if (!own_cyc) begin
          state_d = StIdle;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    cyc_o   = 1'b0;
    stb_o   = 1'b0;
    we_o    = 1'b0;
    sel_o   = '0;
    adr_o   = '0;
    dat_o   = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = dat_i;
    if (state_q == StOwned) begin
      cyc_o            = own_cyc & ~timeout;
      stb_o            = own_cyc & own_stb & ~timeout;
      we_o             = own_we;
      sel_o            = own_sel;
      adr_o            = own_adr;
      dat_o            = own_dat;
      // An ack arriving after the owner dropped cyc belongs to nobody.
      m_ack_o[owner_q] = ack_i & own_cyc;
      m_err_o[owner_q] = timeout;
    end
  end

  assign gnt_o = gnt_q;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= IdxW'(NUM_MASTERS - 1);
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule
